json5_char_window: RTL

Synthesizable byte-stream front end for the hardware JSON5 tokenizer. It is the RTL counterpart of the queue reader: a parametrised circular buffer that accepts characters over a valid/ready stream. It exposes a multi-character lookahead window, so the tokenizer can peek up to `PEEK` characters and consume 0..`PEEK` of them per cycle. It tracks the 1-based line/column of the window head for error reporting, and it closes and reopens on document boundaries.

---
 rtl/json5_stream_pkg.sv | 40 ++++
 rtl/json5_pos_tracker.sv | 41 ++++
 rtl/json5_char_window.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/json5_stream_pkg.sv
// ---------------------------------------------------------------------------
// json5_stream_pkg
// Shared definitions for the JSON5 byte-stream front end and the tokenizer.
//   CHAR_LF      : line-feed character (0x0A), the only line terminator.
//   pos_t        : line/column counter type.
//   pos_pair_t   : {line, col} pair for the position-advance chain.
//   pos_advance  : advance a position over one character, saturating.
// ---------------------------------------------------------------------------
package json5_stream_pkg;

  localparam int POS_W_PKG  = 16;
  // Characters are zero-extended to this width before comparison, so any
  // DATA_W up to 64 bits compares against LF without sign or width surprises.
  localparam int CHAR_W_MAX = 64;

  localparam logic [7:0] CHAR_LF = 8'h0A;

  typedef logic [POS_W_PKG-1:0] pos_t;

  typedef struct packed {
    pos_t line;
    pos_t col;
  } pos_pair_t;

  // LF starts a new line at column 1; every other character (CR included)
  // moves one column right. Both counters stick at all-ones.
  function automatic pos_pair_t pos_advance(input pos_pair_t pos,
                                            input logic [CHAR_W_MAX-1:0] ch);
    pos_pair_t r;
    r = pos;
    if (ch == CHAR_W_MAX'(CHAR_LF)) begin
      if (pos.line != '1) r.line = pos.line + 1'b1;
      r.col = pos_t'(1);
    end else begin
      if (pos.col != '1) r.col = pos.col + 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/json5_pos_tracker.sv
// ---------------------------------------------------------------------------
// json5_pos_tracker
// Combinational next-position calculation for the character window: walks
// the first i_consume_n lanes in order (lane 0 first) through pos_advance.
// Ports:
//   i_line, i_col  : position of lane 0 before the consume.
//   i_lanes        : PEEK lanes, lane i at [i*DATA_W +: DATA_W].
//   i_consume_n    : number of lanes being consumed this cycle.
//   o_line, o_col  : position of the new window head after the consume.
// ---------------------------------------------------------------------------
module json5_pos_tracker
  import json5_stream_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PEEK   = 4,
  parameter int CNT_W  = $clog2(PEEK + 1)
) (
  input  pos_t                     i_line,
  input  pos_t                     i_col,
  input  logic [PEEK*DATA_W-1:0]   i_lanes,
  input  logic [CNT_W-1:0]         i_consume_n,
  output pos_t                     o_line,
  output pos_t                     o_col
);

  pos_pair_t w_pos;

  always_comb begin
    w_pos.line = i_line;
    w_pos.col  = i_col;
    for (int i = 0; i < PEEK; i++) begin
      if (CNT_W'(i) < i_consume_n) begin
        w_pos = pos_advance(w_pos, CHAR_W_MAX'(i_lanes[i*DATA_W +: DATA_W]));
      end
    end
  end

  assign o_line = w_pos.line;
  assign o_col  = w_pos.col;

endmodule

// File: rtl/json5_char_window.sv
// ---------------------------------------------------------------------------
// json5_char_window
// Circular character buffer with a PEEK-wide lookahead window for the JSON5
// tokenizer. Tracks the 1-based line/column of the window head and closes
// after the last character of a document until that document is consumed.
//
// Handshake: a character transfers on a cycle where in_valid && in_ready.
// in_ready comes only from registers (never from in_valid); once asserted
// with in_valid high the character is taken at that clock edge. The consumer
// side has no handshake: consume_n characters are dropped at the edge when
// 0 < consume_n <= peek_count; a larger request drops nothing and latches
// err_overconsume until reset.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset.
//   in_valid/in_ready   : input stream handshake.
//   in_data, in_last    : character and end-of-document marker.
//   peek_data           : lane i at [i*DATA_W +: DATA_W], zero if invalid.
//   peek_count          : valid lanes = min(level, PEEK).
//   peek_eof            : document end lies inside the window.
//   consume_n           : characters to drop from the head this cycle.
//   line, col           : 1-based position of lane 0.
//   level               : characters currently stored.
//   doc_done            : one-cycle pulse after a closed document empties.
//   err_overconsume     : sticky over-consume flag.
//
// POS_W must match json5_stream_pkg::POS_W_PKG because the position chain
// is built on the shared pos_t type; DATA_W may be 8..64.
// ---------------------------------------------------------------------------
module json5_char_window
  import json5_stream_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int PEEK   = 4,
  parameter int POS_W  = POS_W_PKG
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_last,
  output logic [PEEK*DATA_W-1:0]        peek_data,
  output logic [$clog2(PEEK+1)-1:0]     peek_count,
  output logic                          peek_eof,
  input  logic [$clog2(PEEK+1)-1:0]     consume_n,
  output logic [POS_W-1:0]              line,
  output logic [POS_W-1:0]              col,
  output logic [$clog2(DEPTH+1)-1:0]    level,
  output logic                          doc_done,
  output logic                          err_overconsume
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(PEEK + 1);
  localparam int LW = $clog2(DEPTH + 1);

  // Storage and state
  logic [DATA_W-1:0]     r_mem [DEPTH];
  logic [AW-1:0]         r_rd_ptr;
  logic [AW-1:0]         r_wr_ptr;
  logic [LW-1:0]         r_count;
  logic                  r_closed;
  pos_t                  r_line;
  pos_t                  r_col;
  logic                  r_err;
  logic                  r_done;

  // Combinational helpers
  logic [CW-1:0]         w_peek_count;
  logic [PEEK*DATA_W-1:0] w_peek_data;
  logic [AW-1:0]         w_lane_idx;
  logic                  w_ready;
  logic                  w_wr_fire;
  logic                  w_cons_ok;
  logic                  w_over;
  logic [LW-1:0]         w_count_nxt;
  logic                  w_doc_end;
  pos_t                  w_line_nxt;
  pos_t                  w_col_nxt;

  assign w_peek_count = (r_count >= LW'(PEEK)) ? CW'(PEEK) : CW'(r_count);
  assign w_ready      = !r_closed && (r_count < LW'(DEPTH));
  assign w_wr_fire    = in_valid && w_ready;
  assign w_cons_ok    = (consume_n != '0) && (consume_n <= w_peek_count);
  assign w_over       = consume_n > w_peek_count;
  assign w_count_nxt  = r_count + LW'(w_wr_fire)
                        - (w_cons_ok ? LW'(consume_n) : LW'(0));
  // A closed document that drains to empty this edge ends the document.
  assign w_doc_end    = r_closed && (w_count_nxt == '0);

  // Window lanes: only lanes below peek_count show buffer contents, so
  // stale memory never leaks onto the window.
  always_comb begin
    w_peek_data = '0;
    w_lane_idx  = '0;
    for (int i = 0; i < PEEK; i++) begin
      w_lane_idx = r_rd_ptr + AW'(i);
      if (CW'(i) < w_peek_count) begin
        w_peek_data[i*DATA_W +: DATA_W] = r_mem[w_lane_idx];
      end
    end
  end

  json5_pos_tracker #(
    .DATA_W (DATA_W),
    .PEEK   (PEEK),
    .CNT_W  (CW)
  ) u_pos_tracker (
    .i_line      (r_line),
    .i_col       (r_col),
    .i_lanes     (w_peek_data),
    .i_consume_n (consume_n),
    .o_line      (w_line_nxt),
    .o_col       (w_col_nxt)
  );

  // Buffer memory is deliberately not reset; the window masks unused lanes.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_closed <= 1'b0;
      r_line   <= pos_t'(1);
      r_col    <= pos_t'(1);
      r_err    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_done  <= w_doc_end;
      if (w_wr_fire) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_cons_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(consume_n);
      end
      if (w_over) begin
        r_err <= 1'b1;
      end
      if (w_doc_end) begin
        // Pointers already coincide when empty, so only the document
        // state needs restarting.
        r_closed <= 1'b0;
        r_line   <= pos_t'(1);
        r_col    <= pos_t'(1);
      end else begin
        if (w_wr_fire && in_last) begin
          r_closed <= 1'b1;
        end
        if (w_cons_ok) begin
          r_line <= w_line_nxt;
          r_col  <= w_col_nxt;
        end
      end
    end
  end

  assign in_ready        = w_ready;
  assign peek_data       = w_peek_data;
  assign peek_count      = w_peek_count;
  assign peek_eof        = r_closed && (r_count <= LW'(PEEK));
  assign line            = POS_W'(r_line);
  assign col             = POS_W'(r_col);
  assign level           = r_count;
  assign doc_done        = r_done;
  assign err_overconsume = r_err;

endmodule
